// File: rtl/adder_rr_scheduler.sv
// Shares one WIDTH-bit adder among N_REQ requesters using a round-robin
// valid/ready arbiter. Results are returned registered and tagged with the
// id of the requester that supplied the operands.
module adder_rr_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [ID_W-1:0]    op_id;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic               grant_fire;
    logic [ID_W-1:0]    next_ptr;
    int unsigned        scan_idx;
    logic [WIDTH:0]     sum_full;

    logic [WIDTH-1:0]   a_slot [N_REQ];
    logic [WIDTH-1:0]   b_slot [N_REQ];

    // Unpack the flat operand buses into per-requester slots
    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign a_slot[i] = req_a[i*WIDTH +: WIDTH];
        assign b_slot[i] = req_b[i*WIDTH +: WIDTH];
    end

    // Round-robin scan starting at ptr; the lowest offset wins, so scan downwards
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            scan_idx = 32'(ptr) + (k - 1);
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (req_valid[ID_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(scan_idx);
            end
        end
    end

    // Accept strobe is combinational so the handshake completes in the grant cycle
    always_comb begin
        grant_fire = (state == S_IDLE) && ena && grant_found;
        next_ptr   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        req_ready  = (grant_fire && rst_n) ? (N_REQ'(1) << grant_id) : '0;
        sum_full   = {1'b0, op_a} + {1'b0, op_b};
    end

    // Control FSM: IDLE -> EXEC -> HOLD -> IDLE, all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_fire) begin
                        op_a  <= a_slot[grant_id];
                        op_b  <= b_slot[grant_id];
                        op_id <= grant_id;
                        ptr   <= next_ptr;
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    {rsp_carry, rsp_sum} <= sum_full;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
